apb_master: RTL

- APB requester stage that sits directly upstream of the team's APB slaves.
- Accepts single read/write commands on a valid/ready command port.
- Sequences each command through the APB SETUP and ACCESS phases (PSEL/PEN/PWRITE/PADDR/PWDATA), waits on PREADY, and returns PRDATA/PSLVERR as a one-cycle response.
- One outstanding transfer at a time.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master_if.sv | 42 ++++
 rtl/apb_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and default bus widths for the requester and the team's APB slaves.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port and APB bus of the requester, viewed from the master or the far side.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WRITE;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_WDATA;

  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              RSP_ERR;

  logic              PSEL;
  logic              PEN;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
    input  PREADY, PSLVERR, PRDATA,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output PSEL, PEN, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
    output PREADY, PSLVERR, PRDATA,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  PSEL, PEN, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, one-cycle response pulse.
// Build option APB_TIMEOUT_EN adds an ACCESS wait-state limit of TIMEOUT_CYCLES.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         CLK,
  input  logic         RST,
  apb_master_if.master bus
);

  typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] to_cnt_t;

  apb_state_e        state_p0, state_nxt;
  logic              psel_p0, psel_nxt;
  logic              pen_p0, pen_nxt;
  logic              pwrite_p0, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_p0, paddr_nxt;
  logic [DATA_W-1:0] pwdata_p0, pwdata_nxt;
  logic              rsp_vld_p0, rsp_vld_nxt;
  logic [DATA_W-1:0] rsp_rdata_p0, rsp_rdata_nxt;
  logic              rsp_err_p0, rsp_err_nxt;
  logic              cmd_ready;
  logic              timeout_hit;

  assign cmd_ready = (state_p0 == IDLE) && !RST;

`ifdef APB_TIMEOUT_EN
  to_cnt_t to_cnt_p0;

  // Counts PREADY=0 cycles of the current ACCESS; zero on the first ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (RST || (state_p0 != ACCESS)) begin
      to_cnt_p0 <= '0;
    end else if (!bus.PREADY) begin
      to_cnt_p0 <= to_cnt_p0 + 1'b1;
    end
  end

  // Fires on the wait cycle whose increment would reach the limit.
  assign timeout_hit = !bus.PREADY && (to_cnt_p0 == to_cnt_t'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt     = state_p0;
    psel_nxt      = psel_p0;
    pen_nxt       = pen_p0;
    pwrite_nxt    = pwrite_p0;
    paddr_nxt     = paddr_p0;
    pwdata_nxt    = pwdata_p0;
    rsp_vld_nxt   = 1'b0;
    rsp_rdata_nxt = rsp_rdata_p0;
    rsp_err_nxt   = rsp_err_p0;
    unique case (state_p0)
      IDLE: begin
        if (bus.CMD_VALID && cmd_ready) begin
          state_nxt  = SETUP;
          psel_nxt   = 1'b1;
          pen_nxt    = 1'b0;
          pwrite_nxt = bus.CMD_WRITE;
          paddr_nxt  = bus.CMD_ADDR;
          if (bus.CMD_WRITE) begin
            pwdata_nxt = bus.CMD_WDATA;
          end
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
        pen_nxt   = 1'b1;
      end
      ACCESS: begin
        if (bus.PREADY || timeout_hit) begin
          state_nxt   = IDLE;
          psel_nxt    = 1'b0;
          pen_nxt     = 1'b0;
          rsp_vld_nxt = 1'b1;
          // A real PREADY wins over a timeout landing in the same cycle.
          if (bus.PREADY) begin
            rsp_err_nxt   = bus.PSLVERR;
            rsp_rdata_nxt = pwrite_p0 ? '0 : bus.PRDATA;
          end else begin
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        psel_nxt  = 1'b0;
        pen_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Registered APB and response outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      psel_p0      <= 1'b0;
      pen_p0       <= 1'b0;
      pwrite_p0    <= 1'b0;
      paddr_p0     <= '0;
      pwdata_p0    <= '0;
      rsp_vld_p0   <= 1'b0;
      rsp_rdata_p0 <= '0;
      rsp_err_p0   <= 1'b0;
    end else begin
      psel_p0      <= psel_nxt;
      pen_p0       <= pen_nxt;
      pwrite_p0    <= pwrite_nxt;
      paddr_p0     <= paddr_nxt;
      pwdata_p0    <= pwdata_nxt;
      rsp_vld_p0   <= rsp_vld_nxt;
      rsp_rdata_p0 <= rsp_rdata_nxt;
      rsp_err_p0   <= rsp_err_nxt;
    end
  end

  assign bus.CMD_READY = cmd_ready;
  assign bus.PSEL      = psel_p0;
  assign bus.PEN       = pen_p0;
  assign bus.PWRITE    = pwrite_p0;
  assign bus.PADDR     = paddr_p0;
  assign bus.PWDATA    = pwdata_p0;
  assign bus.RSP_VALID = rsp_vld_p0;
  assign bus.RSP_RDATA = rsp_rdata_p0;
  assign bus.RSP_ERR   = rsp_err_p0;

endmodule
